// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and types for the 7-segment scan controller.
// Segment patterns are active-low, bit [0]=a .. bit [6]=g.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic {
        DRIVE = 1'b0,
        BLANK = 1'b1
    } scan_state_e;

    typedef struct packed {
        logic [3:0] val;
        logic       dp;
    } digit_t;

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational 4-bit value to active-low segment pattern.
// Ports: val (0..15) in, seg_n (a..g on [0]..[6]) out.
// Macro SEG7_HEX_EN: when defined, 10..15 show A b C d E F; else blank.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] val,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = SEG_BLANK;
        case (val)
            4'd0:    seg_n = SEG_0;
            4'd1:    seg_n = SEG_1;
            4'd2:    seg_n = SEG_2;
            4'd3:    seg_n = SEG_3;
            4'd4:    seg_n = SEG_4;
            4'd5:    seg_n = SEG_5;
            4'd6:    seg_n = SEG_6;
            4'd7:    seg_n = SEG_7;
            4'd8:    seg_n = SEG_8;
            4'd9:    seg_n = SEG_9;
`ifdef SEG7_HEX_EN
            4'd10:   seg_n = SEG_A;
            4'd11:   seg_n = SEG_B;
            4'd12:   seg_n = SEG_C;
            4'd13:   seg_n = SEG_D;
            4'd14:   seg_n = SEG_E;
            4'd15:   seg_n = SEG_F;
`else
            default: seg_n = SEG_BLANK;
`endif
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed 7-segment scanner with shadow/active digit
// sets swapped at frame end on commit.
// Ports: clk, rst_n (sync, active-low); wr_en/wr_idx/wr_val/wr_dp write
// one shadow digit; commit requests a swap; wr_ready, frame_pulse status;
// seg_n, dp_n, dig_en_n registered active-low pins.
// Macro SEG7_HEX_EN (in seg7_decode) enables hex glyphs for 10..15.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [$clog2(DIGITS)-1:0]  wr_idx,
    input  logic [3:0]                 wr_val,
    input  logic                       wr_dp,
    input  logic                       commit,
    output logic                       wr_ready,
    output logic                       frame_pulse,
    output logic [6:0]                 seg_n,
    output logic                       dp_n,
    output logic [DIGITS-1:0]          dig_en_n
);

    localparam int IDX_W = $clog2(DIGITS);
    localparam int CNT_W = $clog2(SCAN_DIV);

    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(SCAN_DIV - BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

    scan_state_e      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;

    digit_t shadow [DIGITS];
    digit_t active [DIGITS];
    digit_t cur;
    logic   pending;

    logic              frame_end;
    logic              idx_ok;
    logic              wr_acc;
    logic              cm_acc;
    logic [6:0]        dec_seg;
    logic [6:0]        seg_nxt;
    logic              dp_nxt;
    logic [DIGITS-1:0] dig_nxt;

    // cnt counts down the cycles left in the current phase; 0 = last cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= BLANK;
            cnt   <= '0;
            idx   <= IDX_LAST;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
        end
    end

    assign cur = active[idx];

    seg7_decode u_dec (
        .val   (cur.val),
        .seg_n (dec_seg)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt - CNT_W'(1);
        idx_nxt   = idx;
        case (state)
            DRIVE: begin
                if (cnt == '0) begin
                    state_nxt = BLANK;
                    cnt_nxt   = BLANK_LAST;
                end
            end
            BLANK: begin
                if (cnt == '0) begin
                    state_nxt = DRIVE;
                    cnt_nxt   = DRIVE_LAST;
                    idx_nxt   = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
                end
            end
            default: state_nxt = BLANK;
        endcase

        seg_nxt = SEG_BLANK;
        dp_nxt  = 1'b1;
        dig_nxt = '1;
        if (state == DRIVE) begin
            seg_nxt      = dec_seg;
            dp_nxt       = ~cur.dp;
            dig_nxt[idx] = 1'b0;
        end
    end

    assign frame_end   = (state == BLANK) && (cnt == '0) && (idx == IDX_LAST);
    assign wr_ready    = ~pending;
    assign frame_pulse = frame_end && pending;
    assign idx_ok      = {1'b0, wr_idx} < (IDX_W + 1)'(DIGITS);
    assign wr_acc      = wr_en && wr_ready && idx_ok;
    assign cm_acc      = commit && wr_ready;

    // pending is still 0 on a frame-end cycle that accepts a commit,
    // so that commit waits for the following frame end.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DIGITS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
            pending <= 1'b0;
        end else begin
            if (wr_acc) begin
                shadow[wr_idx] <= {wr_val, wr_dp};
            end
            if (frame_pulse) begin
                for (int i = 0; i < DIGITS; i++) begin
                    active[i] <= shadow[i];
                end
                pending <= 1'b0;
            end else if (cm_acc) begin
                pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_n    <= SEG_BLANK;
            dp_n     <= 1'b1;
            dig_en_n <= '1;
        end else begin
            seg_n    <= seg_nxt;
            dp_n     <= dp_nxt;
            dig_en_n <= dig_nxt;
        end
    end

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 Parameter DIGITS, default 4: number of multiplexed digits (2..8).
REQ-002 Parameter SCAN_DIV, default 50000: clock cycles per digit slot (1 ms at 50 MHz).
REQ-003 Parameter BLANK_CYC, default 500: blanking cycles at the end of each slot; 1 <= BLANK_CYC < SCAN_DIV.
REQ-004 clk  in  1  system clock; one clock, all logic on its rising edge.
REQ-005 rst_n  in  1  reset; synchronous, active-low.
REQ-006 wr_en  in  1  write strobe for one shadow digit.
REQ-007 wr_idx  in  clog2(DIGITS)  digit index to write.
REQ-008 wr_val  in  4  digit value 0..15.
REQ-009 wr_dp  in  1  decimal point for the digit (1 = lit).
REQ-010 commit  in  1  request to copy the shadow set to the active set at the next frame end.
REQ-011 wr_ready  out  1  high when writes and commit are accepted.
REQ-012 frame_pulse  out  1  one-cycle pulse on the cycle the active set is updated.
REQ-013 seg_n  out  7  segments a..g on bits [0]..[6]; active-low.
REQ-014 dp_n  out  1  decimal point; active-low.
REQ-015 dig_en_n  out  DIGITS  digit common enables; active-low; at most one low.

Function
REQ-016 The FSM has two states: DRIVE for SCAN_DIV-BLANK_CYC cycles, then BLANK for BLANK_CYC cycles. After BLANK, the digit index increments modulo DIGITS and the FSM returns to DRIVE.
REQ-017 In DRIVE, the active entry of the current digit is decoded onto seg_n/dp_n, and dig_en_n[idx] is 0.
REQ-018 In BLANK, seg_n = all 1, dp_n = 1 and dig_en_n = all 1.
REQ-019 All pin outputs are registered, with one cycle of latency from the FSM state.
REQ-020 One frame is DIGITS*SCAN_DIV cycles. Frame end is the last BLANK cycle of digit DIGITS-1.
REQ-021 Decode values 0..9 to standard patterns, e.g. 0 -> seg_n 7'b1000000, 1 -> 7'b1111001, 8 -> 7'b0000000.
REQ-022 A write is accepted when wr_en && wr_ready, and updates shadow[wr_idx] on that edge. Writes while wr_ready=0 are ignored.
REQ-023 wr_idx >= DIGITS is ignored.
REQ-024 A commit is accepted when commit && wr_ready. wr_ready goes low on the next cycle.
REQ-025 At frame end with a commit pending: shadow is copied to active, frame_pulse = 1 that cycle, and wr_ready returns high on the following cycle.
REQ-026 If write and commit are accepted on the same cycle, the write is included in the commit.
REQ-027 A commit accepted on the frame-end cycle itself takes effect at the following frame end.
REQ-028 Without a pending commit, frame_pulse stays 0 and active is unchanged.
REQ-029 Slot and digit counters wrap with no gap cycles between frames.

Reset
REQ-030 While rst_n=0 on a clock edge:
- shadow and active are cleared to value 0, dp 0
- pending commit is cleared; wr_ready = 1; frame_pulse = 0
- seg_n = all 1, dp_n = 1, dig_en_n = all 1
- FSM goes to BLANK of digit DIGITS-1 with 1 cycle remaining
REQ-031 Reset mid-frame or mid-commit discards all state. The first DRIVE after release is digit 0, starting 2 cycles after rst_n rises (one BLANK cycle, then one output-register cycle).

Configuration
REQ-032 With SEG7_HEX_EN defined, values 10..15 display A, b, C, d, E, F.
REQ-033 Without SEG7_HEX_EN, values 10..15 display blank (seg_n all 1, dp per wr_dp).

Structure
REQ-034 Shared package seg7_pkg holds:
- segment pattern constants for 0..F
- the blank pattern
- the FSM state typedef (DRIVE, BLANK)
REQ-035 Sub-module seg7_decode is the combinational value-to-segment decoder, and is the only place SEG7_HEX_EN is tested.

Verification
REQ-036 Scenarios use SCAN_DIV=10 and BLANK_CYC=2.
REQ-037 Reset release -> dig_en_n all 1 for 2 cycles, then dig_en_n=4'b1110 with seg_n=7'b1000000 for 8 cycles, then 2 blank cycles.
REQ-038 Write idx1=8 with dp, then commit -> wr_ready low until frame end. frame_pulse occurs at cycle 40 after the first DRIVE. In the next frame, digit 1 shows seg_n=7'b0000000, dp_n=0.
REQ-039 Write while wr_ready=0 (idx2=5) -> ignored; digit 2 remains 0 after the next commit.
REQ-040 Write and commit on the same cycle (idx3=1) -> digit 3 shows 7'b1111001 after frame end.
REQ-041 Value 12 committed -> shows 7'b1000110 with SEG7_HEX_EN defined, and 7'b1111111 without it.
REQ-042 Assert rst_n=0 during a pending commit -> pending cleared, wr_ready=1, no frame_pulse, all digits show 0 after restart.
